apb_slave: RTL and testbench



---
 rtl/apb_slave_pkg.sv | 12 +
 rtl/apb_slave_mem.sv | 35 +++
 rtl/apb_slave.sv | 96 +++++++++
 tb/tb_apb_slave.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg: shared FSM state encoding and default sizes for the APB completer.
//   No ports. Provides state_t (IDLE/SETUP/ACCESS), ADDR_W_DEF, DATA_W_DEF, ERR_BASE_DEF.
package apb_slave_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;
    localparam int         ADDR_W_DEF   = 8;
    localparam int         DATA_W_DEF   = 32;
    localparam logic [7:0] ERR_BASE_DEF = 8'hF0;
endpackage

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: 2**ADDR_W x DATA_W array with one write port and one registered read port.
//   i_clk            clock
//   i_rst            sync active-high reset of the read register only (array keeps contents)
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr     read request; o_rdata updates on the next rising edge and holds otherwise
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Array kept free of reset so contents survive it and it can map onto RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/apb_slave.sv
// apb_slave: APB3-style completer over a 2**ADDR_W x DATA_W register array with wait states.
//   pclk     clock (rising edge)
//   presetn  sync reset, active HIGH despite the name; storage is not cleared
//   paddr/pwrite/psel/penable/pwdata   APB request
//   prdata   registered read data, valid with pready in a read ACCESS
//   pready   completion strobe, high only in ACCESS once the wait counter is zero
//   pslverr  (only with APB_SLAVE_SLVERR_EN) error for captured addresses >= ERR_BASE;
//            writes there are dropped, reads return data
module apb_slave
    import apb_slave_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_STATES = 0
`ifdef APB_SLAVE_SLVERR_EN
    ,
    parameter logic [ADDR_W-1:0] ERR_BASE = ERR_BASE_DEF
`endif
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    input  logic              psel,
    input  logic              penable,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
`ifdef APB_SLAVE_SLVERR_EN
    output logic              pslverr,
`endif
    output logic              pready
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t            r_state;
    logic [3:0]        r_wcnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic              w_pready;
    logic              w_done;
    logic              w_we;
    logic              w_re;

    assign w_pready = (r_state == ACCESS) && (r_wcnt == 4'd0);
    assign w_done   = psel && penable && w_pready;
    // Read is launched from SETUP so the registered data lines up with pready.
    assign w_re     = (r_state == SETUP) && !pwrite && !presetn;

`ifdef APB_SLAVE_SLVERR_EN
    logic w_err;
    assign w_err   = r_addr >= ERR_BASE;
    assign w_we    = w_done && r_write && !w_err && !presetn;
    assign pslverr = w_pready && w_err;
`else
    assign w_we    = w_done && r_write && !presetn;
`endif

    assign pready = w_pready;

    always_ff @(posedge pclk) begin
        if (presetn) begin
            r_state <= IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            case (r_state)
                IDLE:   r_state <= (psel && !penable) ? SETUP : IDLE;
                SETUP: begin
                    r_addr  <= paddr;
                    r_write <= pwrite;
                    r_wcnt  <= WS;
                    r_state <= !psel ? IDLE : (penable ? ACCESS : SETUP);
                end
                ACCESS: begin
                    // Dropping psel before completion aborts without writing.
                    if (!psel || w_done) r_state <= IDLE;
                    else if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    apb_slave_mem #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem (
        .i_clk  (pclk),
        .i_rst  (presetn),
        .i_we   (w_we),
        .i_waddr(r_addr),
        .i_wdata(pwdata),
        .i_re   (w_re),
        .i_raddr(paddr),
        .o_rdata(prdata)
    );
endmodule

// File: tb/tb_apb_slave.sv
// tb_apb_slave: scoreboard bench for apb_slave; two instances (WAIT_STATES 0 and 2).
//   Stimulus tasks push expected completions; a negedge monitor pops and compares.
//   Define APB_SLAVE_SLVERR_EN to also exercise pslverr.
module tb_apb_slave;
    typedef struct {
        int          d;
        logic        rd;
        logic [31:0] data;
        int          chk;
        int          waits;
        logic        err;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  psel = '0;
    logic [1:0]  penable = '0;
    logic [1:0]  pwrite = '0;
    logic [7:0]  paddr [2] = '{8'h0, 8'h0};
    logic [31:0] pwdata [2] = '{32'h0, 32'h0};
    logic [31:0] prdata [2];
    logic [1:0]  pready;
`ifdef APB_SLAVE_SLVERR_EN
    logic [1:0]  pslverr;
`endif

    int   tests = 0;
    int   failed = 0;
    int   wc [2] = '{0, 0};
    exp_t sb [$];

    always #5 clk = ~clk;

    apb_slave #(.WAIT_STATES(0)) u_ws0 (
        .pclk(clk), .presetn(rst), .paddr(paddr[0]), .pwrite(pwrite[0]), .psel(psel[0]),
        .penable(penable[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
`ifdef APB_SLAVE_SLVERR_EN
        .pslverr(pslverr[0]),
`endif
        .pready(pready[0])
    );

    apb_slave #(.WAIT_STATES(2)) u_ws2 (
        .pclk(clk), .presetn(rst), .paddr(paddr[1]), .pwrite(pwrite[1]), .psel(psel[1]),
        .penable(penable[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
`ifdef APB_SLAVE_SLVERR_EN
        .pslverr(pslverr[1]),
`endif
        .pready(pready[1])
    );

    // eq=1: act must equal exp; eq=0: act must differ from exp
    task automatic cmp(string n, logic [31:0] act, logic [31:0] exp, bit eq = 1'b1);
        tests++;
        if (eq ? (act !== exp) : (act === exp)) begin
            failed++;
            $display("FAIL %s: got %h, %s %h", n, act, eq ? "expected" : "must differ from", exp);
        end
    endtask

    // Monitor: every completion must match the oldest expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (psel[d] && penable[d] && pready[d]) begin
                if (sb.size() == 0 || sb[0].d != d) begin
                    cmp($sformatf("unexpected completion dut%0d", d), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    cmp({e.name, " waits"}, 32'(wc[d]), 32'(e.waits));
                    if (e.rd && e.chk == 1) cmp({e.name, " prdata"}, prdata[d], e.data);
                    if (e.rd && e.chk == 2) cmp({e.name, " prdata"}, prdata[d], e.data, 1'b0);
`ifdef APB_SLAVE_SLVERR_EN
                    cmp({e.name, " pslverr"}, 32'(pslverr[d]), 32'(e.err));
`endif
                end
                wc[d] = 0;
            end else begin
`ifdef APB_SLAVE_SLVERR_EN
                if (!pready[d]) cmp($sformatf("pslverr idle dut%0d", d), 32'(pslverr[d]), 32'd0);
`endif
                wc[d] = (psel[d] && penable[d]) ? wc[d] + 1 : 0;
            end
        end
    end

    // mode 0 normal, 1 abort in ACCESS, 2 hold psel&penable 3 cycles after completion.
    // chk -1 selects the default data check (equality for reads, none for writes).
    task automatic xfer(int d, bit wr, logic [7:0] a, logic [31:0] v, string n,
                        int mode = 0, int chk = -1);
        int   k;
        exp_t e;
        if (mode != 1) begin
            e.d    = d;
            e.rd   = !wr;
            e.data = v;
            e.chk  = (chk >= 0) ? chk : (wr ? 0 : 1);
            // The DUT's SETUP state already sees penable high, so the master
            // observes one low-pready cycle on top of WAIT_STATES.
            e.waits = (d == 0 ? 0 : 2) + 1;
`ifdef APB_SLAVE_SLVERR_EN
            e.err = a >= 8'hF0;
`else
            e.err = 1'b0;
`endif
            e.name = n;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a;
        pwdata[d] = wr ? v : 32'h0;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        if (mode == 1) begin
            @(posedge clk); #1;
            psel[d] = 1'b0; penable[d] = 1'b0;
            return;
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!pready[d] && k < 20);
        if (!pready[d]) cmp({n, " timeout pready"}, 32'(pready[d]), 32'd1);
        @(posedge clk); #1;
        if (mode == 2) begin
            pwdata[d] = ~v;
            repeat (3) begin
                @(negedge clk);
                cmp({n, " hold pready"}, 32'(pready[d]), 32'd0);
            end
            @(posedge clk); #1;
        end
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            cmp($sformatf("reset pready dut%0d", d), 32'(pready[d]), 32'd0);
            cmp($sformatf("reset prdata dut%0d", d), prdata[d], 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        xfer(0, 1'b1, 8'h24, 32'h12153524, "wr24");
        xfer(0, 1'b0, 8'h24, 32'h12153524, "rd24 pre-reset");
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        cmp("prdata after reset", prdata[0], 32'h0);
        cmp("pready after reset", 32'(pready[0]), 32'd0);
        xfer(0, 1'b0, 8'h24, 32'h12153524, "rd24 post-reset");

        xfer(0, 1'b1, 8'h00, 32'hA5A50000, "wr00");
        xfer(0, 1'b1, 8'hEF, 32'h0000EFEF, "wrEF");
        xfer(0, 1'b0, 8'h00, 32'hA5A50000, "rd00");
        xfer(0, 1'b0, 8'hEF, 32'h0000EFEF, "rdEF");

        xfer(1, 1'b1, 8'h81, 32'hDEADBEEF, "ws2 wr81");
        xfer(1, 1'b0, 8'h81, 32'hDEADBEEF, "ws2 rd81");

        xfer(1, 1'b1, 8'h40, 32'h11111111, "ws2 wr40");
        xfer(1, 1'b1, 8'h40, 32'h22222222, "ws2 abort40", 1);
        xfer(1, 1'b0, 8'h40, 32'h11111111, "ws2 rd40 after abort");

        xfer(0, 1'b1, 8'h55, 32'hCAFEF00D, "wr55 hold", 2);
        xfer(0, 1'b0, 8'h55, 32'hCAFEF00D, "rd55 after hold");

        @(posedge clk); #1;
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 8'h55; pwdata[0] = 32'h0BADBAD0;
        repeat (3) begin
            @(negedge clk);
            cmp("no-setup pready", 32'(pready[0]), 32'd0);
        end
        @(posedge clk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        xfer(0, 1'b0, 8'h55, 32'hCAFEF00D, "rd55 after no-setup");

`ifdef APB_SLAVE_SLVERR_EN
        xfer(0, 1'b1, 8'hF3, 32'h5A5A5A5A, "err wrF3");
        xfer(0, 1'b1, 8'h10, 32'h13579BDF, "ok wr10");
        xfer(0, 1'b0, 8'h10, 32'h13579BDF, "ok rd10");
        xfer(0, 1'b0, 8'hF3, 32'h5A5A5A5A, "err rdF3", 0, 2);
        xfer(1, 1'b1, 8'hF0, 32'h77777777, "ws2 err wrF0");
`endif

        repeat (3) @(posedge clk);
        cmp("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
